// File: rtl/soda_pkg.sv
// Shared definitions for the soda vending sequencer.
// Holds the default datapath width, change unit, product prices, the FSM
// state encoding, and the price lookup used by the sequencer.
package soda_pkg;

    localparam int W           = 8;
    localparam int CHANGE_UNIT = 5;
    localparam int PRICE0      = 50;
    localparam int PRICE1      = 75;
    localparam int PRICE2      = 100;
    localparam int PRICE3      = 125;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ADD    = 3'd2,
        ST_DISP   = 3'd3,
        ST_REFUND = 3'd4,
        ST_CHANGE = 3'd5
    } state_t;

    // Price of product s. The price table can be overridden by the caller so
    // that a parameterised top can pass its own prices through.
    function automatic int price_of(input logic [1:0] s,
                                    input int p0 = PRICE0,
                                    input int p1 = PRICE1,
                                    input int p2 = PRICE2,
                                    input int p3 = PRICE3);
        case (s)
            2'd0:    return p0;
            2'd1:    return p1;
            2'd2:    return p2;
            default: return p3;
        endcase
    endfunction

endpackage

// File: rtl/soda_idle_timer.sv
// Inactivity counter for the vending sequencer.
// Ports:
//   clk, rst : clock and asynchronous active-low reset
//   clr      : synchronous clear (has priority over en)
//   en       : count enable; the counter saturates at TIMEOUT_CYC-1
//   tc       : terminal count, high while the counter sits at TIMEOUT_CYC-1
module soda_idle_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int            CW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != TERM)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = (cnt == TERM);

endmodule

// File: rtl/soda_vend_sequencer.sv
// Multi-product soda vending sequencer.
// Accumulates coin credit, latches a product selection, dispenses once the
// credit covers the price, then pays change back as CHANGE_UNIT pulses.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   coin_valid/val    : coin strobe and value
//   sel_valid/sel     : selection strobe and product index
//   cancel            : refund request strobe
//   credit            : current credit register
//   disp/disp_sel     : one-cycle dispense pulse and product index
//   change_pulse      : one pulse per CHANGE_UNIT returned
//   coin_reject       : one-cycle pulse for a coin that was not accepted
//   busy              : high in ADD, DISP, REFUND, CHANGE
//   state_dbg         : current FSM state encoding (soda_pkg::state_t)
// Handshake: all inputs are single-cycle strobes sampled on posedge clk;
// there is no back-pressure, a strobe that cannot be taken is dropped (and a
// dropped coin is reported on coin_reject the following cycle).
module soda_vend_sequencer #(
    parameter int W           = soda_pkg::W,
    parameter int PRICE0      = soda_pkg::PRICE0,
    parameter int PRICE1      = soda_pkg::PRICE1,
    parameter int PRICE2      = soda_pkg::PRICE2,
    parameter int PRICE3      = soda_pkg::PRICE3,
    parameter int CHANGE_UNIT = soda_pkg::CHANGE_UNIT,
    parameter int MAX_CREDIT  = 250,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         coin_valid,
    input  logic [W-1:0] coin_val,
    input  logic         sel_valid,
    input  logic [1:0]   sel,
    input  logic         cancel,
    output logic [W-1:0] credit,
    output logic         disp,
    output logic [1:0]   disp_sel,
    output logic         change_pulse,
    output logic         coin_reject,
    output logic         busy,
    output logic [2:0]   state_dbg
);

    import soda_pkg::*;

    localparam logic [W-1:0] UNIT = W'(CHANGE_UNIT);

    state_t       state;
    logic [W-1:0] rem;
    logic [W-1:0] coin_hold;
    logic [1:0]   sel_q;
    logic         sel_pend;

    logic         tmr_clr;
    logic         tmr_en;
    logic         tmr_tc;

    logic [W:0]   credit_ext;
    logic [W:0]   sum_ext;
    logic [W:0]   price_ext;
    logic [W-1:0] disp_rem;
    logic         coin_fits;
    logic         timeout;
    logic         coin_accept;

    // Ceiling test is done one bit wider so credit+coin cannot wrap.
    assign credit_ext  = {1'b0, credit};
    assign sum_ext     = credit_ext + {1'b0, coin_val};
    assign price_ext   = (W+1)'(price_of(sel_q, PRICE0, PRICE1, PRICE2, PRICE3));
    assign disp_rem    = credit - price_ext[W-1:0];
    assign coin_fits   = (sum_ext <= (W+1)'(MAX_CREDIT));
    assign timeout     = tmr_tc && (credit != '0);
    // A coin is only taken in WAIT when neither cancel nor timeout outranks it.
    assign coin_accept = (state == ST_WAIT) && !cancel && !timeout && coin_fits;

    assign tmr_clr   = coin_valid || sel_valid || (credit == '0) || (state != ST_WAIT);
    assign tmr_en    = (state == ST_WAIT);
    assign state_dbg = state;

    soda_idle_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_idle_timer (
        .clk(clk),
        .rst(rst),
        .clr(tmr_clr),
        .en (tmr_en),
        .tc (tmr_tc)
    );

    // Outputs are registered against the state being entered, so disp is
    // high exactly while in DISP and change_pulse exactly while in CHANGE
    // with rem >= CHANGE_UNIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_INIT;
            credit       <= '0;
            rem          <= '0;
            coin_hold    <= '0;
            sel_q        <= '0;
            sel_pend     <= 1'b0;
            disp         <= 1'b0;
            disp_sel     <= '0;
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            disp         <= 1'b0;
            change_pulse <= 1'b0;
            coin_reject  <= coin_valid && !coin_accept;
            case (state)
                ST_INIT: begin
                    credit   <= '0;
                    sel_pend <= 1'b0;
                    busy     <= 1'b0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cancel || timeout) begin
                        busy  <= 1'b1;
                        state <= ST_REFUND;
                    end else if (coin_valid) begin
                        if (coin_fits) begin
                            coin_hold <= coin_val;
                            busy      <= 1'b1;
                            state     <= ST_ADD;
                        end
                    end else if (sel_valid) begin
                        sel_q    <= sel;
                        sel_pend <= 1'b1;
                    end else if (sel_pend && (credit_ext >= price_ext)) begin
                        disp     <= 1'b1;
                        disp_sel <= sel_q;
                        busy     <= 1'b1;
                        state    <= ST_DISP;
                    end
                end
                ST_ADD: begin
                    credit <= credit + coin_hold;
                    busy   <= 1'b0;
                    state  <= ST_WAIT;
                end
                ST_DISP: begin
                    rem          <= disp_rem;
                    credit       <= '0;
                    sel_pend     <= 1'b0;
                    change_pulse <= (disp_rem >= UNIT);
                    state        <= ST_CHANGE;
                end
                ST_REFUND: begin
                    rem          <= credit;
                    credit       <= '0;
                    sel_pend     <= 1'b0;
                    change_pulse <= (credit >= UNIT);
                    state        <= ST_CHANGE;
                end
                ST_CHANGE: begin
                    // Residual below one unit is forfeited on exit.
                    if (rem >= UNIT) begin
                        rem          <= rem - UNIT;
                        change_pulse <= ((rem - UNIT) >= UNIT);
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_INIT;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soda_vend_sequencer.sv
module tb_soda_vend_sequencer;

    localparam int         W      = 8;
    localparam int         UNIT   = 5;
    localparam int         MAXC   = 250;
    localparam int         TMO    = 1000;
    localparam logic [2:0] S_INIT = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_CHG  = 3'd5;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         coin_valid = 1'b0;
    logic [W-1:0] coin_val   = '0;
    logic         sel_valid  = 1'b0;
    logic [1:0]   sel        = '0;
    logic         cancel     = 1'b0;
    logic [W-1:0] credit;
    logic         disp;
    logic [1:0]   disp_sel;
    logic         change_pulse;
    logic         coin_reject;
    logic         busy;
    logic [2:0]   state_dbg;

    soda_vend_sequencer dut (
        .clk(clk), .rst(rst),
        .coin_valid(coin_valid), .coin_val(coin_val),
        .sel_valid(sel_valid), .sel(sel), .cancel(cancel),
        .credit(credit), .disp(disp), .disp_sel(disp_sel),
        .change_pulse(change_pulse), .coin_reject(coin_reject),
        .busy(busy), .state_dbg(state_dbg)
    );

    // scoreboard
    logic [W-1:0] exp_q[$];   // dispense (0x10|sel) and reject (0x20) events
    logic [W-1:0] pulse_q[$]; // one entry of UNIT per expected change pulse
    int           n_checks = 0;
    int           n_errors = 0;
    int           exp_credit = 0;
    bit           mon_en = 1'b0;
    int           prices[4] = '{50, 75, 100, 125};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst && mon_en) begin
            if (disp) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
                check("disp_evt", {4'h1, 2'b00, disp_sel}, e);
            end
            if (coin_reject) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
                check("reject_evt", 8'h20, e);
            end
            if (change_pulse) begin
                e = (pulse_q.size() > 0) ? pulse_q.pop_front() : 8'hFF;
                check("change_evt", UNIT, e);
            end
        end
    end

    // model helpers
    task automatic expect_change(input int amount);
        for (int i = 0; i < amount / UNIT; i++) pulse_q.push_back(W'(UNIT));
    endtask

    task automatic expect_vend(input int s);
        exp_q.push_back(8'h10 | W'(s));
        expect_change(exp_credit - prices[s]);
        exp_credit = 0;
    endtask

    // driver tasks: entered just after a negedge, return just after a negedge
    task automatic raw_coin(input int v);
        coin_valid = 1'b1;
        coin_val   = W'(v);
        @(negedge clk);
        coin_valid = 1'b0;
    endtask

    task automatic insert_coin(input int v);
        if (exp_credit + v <= MAXC) exp_credit += v;
        else exp_q.push_back(8'h20);
        raw_coin(v);
        @(negedge clk);
        check("credit_after_coin", credit, exp_credit);
    endtask

    task automatic select(input int s);
        sel_valid = 1'b1;
        sel       = 2'(s);
        @(negedge clk);
        sel_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(state_dbg == S_WAIT && !busy) && n < 600) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_bound"}, (n < 600), 1);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_evt_q"}, exp_q.size(), 0);
        check({tag, "_pulse_q"}, pulse_q.size(), 0);
    endtask

    initial begin
        int n;
        // reset
        #1 rst = 1'b0;
        #1;
        check("rst_credit", credit, 0);
        check("rst_disp", disp, 0);
        check("rst_change", change_pulse, 0);
        check("rst_busy", busy, 0);
        check("rst_reject", coin_reject, 0);
        check("rst_state", state_dbg, S_INIT);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_state", state_dbg, S_WAIT);
        mon_en = 1'b1;

        // exact pay
        insert_coin(25);
        insert_coin(25);
        check("exact_credit", credit, 50);
        expect_vend(0);
        select(0);
        check("exact_disp_early", disp, 0);
        @(negedge clk);
        check("exact_disp", disp, 1);
        check("exact_disp_sel", disp_sel, 0);
        wait_idle("exact");
        check("exact_credit_zero", credit, 0);
        check_drained("exact");

        // overpay with change
        insert_coin(100);
        insert_coin(25);
        expect_vend(1);
        select(1);
        @(negedge clk);
        check("ovp_disp", disp, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("ovp_pulse_run", change_pulse, 1);
        end
        @(negedge clk);
        check("ovp_pulse_end", change_pulse, 0);
        wait_idle("ovp");
        check_drained("ovp");

        // pending selection
        insert_coin(100);
        select(3);
        repeat (4) @(negedge clk);
        check("pend_no_disp", disp, 0);
        check("pend_credit", credit, 100);
        insert_coin(25);
        expect_vend(3);
        @(negedge clk);
        check("pend_disp", disp, 1);
        check("pend_disp_sel", disp_sel, 3);
        wait_idle("pend");
        check_drained("pend");

        // ceiling and rejects
        insert_coin(100);
        insert_coin(100);
        insert_coin(25);
        insert_coin(15);
        insert_coin(25);           // 265 > 250: rejected
        check("ceil_credit_held", credit, 240);
        insert_coin(10);           // exactly 250: accepted
        check("ceil_exact_max", credit, 250);
        expect_vend(2);
        select(2);
        @(negedge clk);
        check("ceil_disp", disp, 1);
        @(negedge clk);
        check("ceil_in_change", state_dbg, S_CHG);
        exp_q.push_back(8'h20);
        raw_coin(5);
        wait_idle("ceil");
        check_drained("ceil");

        // cancel with a simultaneous coin (coin dropped and rejected)
        insert_coin(25);
        insert_coin(10);
        insert_coin(2);
        exp_q.push_back(8'h20);
        expect_change(exp_credit);
        exp_credit = 0;
        cancel     = 1'b1;
        coin_valid = 1'b1;
        coin_val   = W'(5);
        @(negedge clk);
        cancel     = 1'b0;
        coin_valid = 1'b0;
        wait_idle("cancel");
        check("cancel_credit", credit, 0);
        check_drained("cancel");

        // inactivity timeout
        insert_coin(10);
        expect_change(exp_credit);
        exp_credit = 0;
        n = 0;
        while (!busy && n < 1500) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", n, TMO);
        wait_idle("timeout");
        check_drained("timeout");

        // async reset in the middle of a change train
        mon_en = 1'b0;
        insert_coin(100);
        insert_coin(100);
        select(0);
        @(negedge clk);
        check("arst_disp", disp, 1);
        repeat (3) @(negedge clk);
        check("arst_pre_pulse", change_pulse, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_change", change_pulse, 0);
        check("arst_credit", credit, 0);
        check("arst_busy", busy, 0);
        check("arst_state", state_dbg, S_INIT);
        @(negedge clk);
        rst = 1'b1;
        exp_credit = 0;
        #1 check("arst_release_state", state_dbg, S_INIT);
        @(negedge clk);
        check("arst_wait_state", state_dbg, S_WAIT);
        mon_en = 1'b1;
        repeat (8) @(negedge clk);
        check_drained("arst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
